// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between pc_sequencer (master) and imem (slave).
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side PC owner: sequences imem fetches, applies stalls/redirects/timeout.
// Optional macro PC_MISALIGN_TRAP_EN traps misaligned redirect targets instead of aligning them.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   br_taken,
    input  logic [31:0]            br_target,
    input  logic                   jump,
    input  logic [31:0]            jump_target,
    pc_sequencer_if.master         imem,
    output logic                   if_valid,
    output logic [31:0]            if_pc,
    output logic [31:0]            pc_out,
`ifdef PC_MISALIGN_TRAP_EN
    output logic                   misalign,
    output logic [31:0]            fault_addr,
`endif
    output logic                   fetch_err
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [31:0] pend_target;
    logic        pend_flag;
    logic [7:0]  to_cnt;

    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] target;

    // Jump outranks branch whenever both resolve in the same cycle.
    assign redirect   = jump | br_taken;
    assign raw_target = jump ? jump_target : br_target;

`ifdef PC_MISALIGN_TRAP_EN
    logic pend_bad;
    logic target_bad;
    assign target     = raw_target;
    assign target_bad = redirect && (raw_target[1:0] != 2'b00);
`else
    assign target     = raw_target & ~32'h0000_0003;
`endif

    assign imem.imem_req  = (state == S_FETCH);
    assign imem.imem_addr = pc_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_BOOT;
            pc_out      <= RESET_VECTOR;
            pend_target <= 32'h0;
            pend_flag   <= 1'b0;
            to_cnt      <= 8'h0;
            if_valid    <= 1'b0;
            if_pc       <= 32'h0;
            fetch_err   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            pend_bad    <= 1'b0;
            misalign    <= 1'b0;
            fault_addr  <= 32'h0;
`endif
        end else begin
            if_valid <= 1'b0;
            case (state)
                S_BOOT: state <= stall ? S_HOLD : S_FETCH;

                S_FETCH: begin
                    if (imem.imem_ready) begin
                        to_cnt    <= 8'h0;
                        pend_flag <= 1'b0;
                        if_pc     <= pc_out;
                        if_valid  <= !(redirect || pend_flag);
`ifdef PC_MISALIGN_TRAP_EN
                        pend_bad  <= 1'b0;
                        // A newer aligned redirect supersedes a misaligned pending one.
                        if (target_bad || (!redirect && pend_flag && pend_bad)) begin
                            state      <= S_ERR;
                            fetch_err  <= 1'b1;
                            misalign   <= 1'b1;
                            fault_addr <= target_bad ? raw_target : pend_target;
                        end else
`endif
                        begin
                            if (redirect)
                                pc_out <= target;
                            else if (pend_flag)
                                pc_out <= pend_target;
                            else
                                pc_out <= pc_out + 32'd4;
                            state <= stall ? S_HOLD : S_FETCH;
                        end
                    end else begin
                        if (redirect) begin
                            pend_target <= target;
                            pend_flag   <= 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
                            pend_bad    <= target_bad;
`endif
                        end
                        if (to_cnt == TO_LAST) begin
                            state     <= S_ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end
                end

                S_HOLD: begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (target_bad) begin
                        state      <= S_ERR;
                        fetch_err  <= 1'b1;
                        misalign   <= 1'b1;
                        fault_addr <= raw_target;
                    end else
`endif
                    begin
                        if (redirect)
                            pc_out <= target;
                        if (!stall)
                            state <= S_FETCH;
                    end
                end

                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle vector table plus a delivery scoreboard.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] pc_out;
    logic        fetch_err;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] fault_addr;
`endif

    pc_sequencer_if imem_bus ();

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .imem        (imem_bus.master),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .pc_out      (pc_out),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign    (misalign),
        .fault_addr  (fault_addr),
`endif
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        deliver;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          compared = 0;
    int          mismatched = 0;

    function automatic vec_t mk(logic s, logic r, logic j, logic [31:0] jt, logic b,
                                logic [31:0] bt, logic req, logic [31:0] addr, logic dlv);
        vec_t v;
        v.stall = s;  v.ready = r;  v.jump = j;  v.jt = jt;  v.br = b;  v.bt = bt;
        v.exp_req = req;  v.exp_addr = addr;  v.deliver = dlv;  v.exp_err = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge; check the fetch bus before and the error flag after the rising edge.
    task automatic applyStimulus(input string tag, input vec_t v);
        stall = v.stall;  imem_bus.imem_ready = v.ready;
        jump = v.jump;    jump_target = v.jt;
        br_taken = v.br;  br_target = v.bt;
        if (v.deliver) sb.push_back(v.exp_addr);
        #1;
        checkOutput({tag, "_req"}, 32'(imem_bus.imem_req), 32'(v.exp_req));
        if (v.exp_req) checkOutput({tag, "_addr"}, imem_bus.imem_addr, v.exp_addr);
        @(posedge clk);
        #1;
        checkOutput({tag, "_err"}, 32'(fetch_err), 32'(v.exp_err));
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (if_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL sb_unexpected: got if_valid with if_pc %h, required no delivery", if_pc);
            end else begin
                checkOutput("sb_if_pc", if_pc, sb.pop_front());
            end
        end
    end

    initial begin
        vec_t v;
        imem_bus.imem_ready = 1'b0;

        //          s  r  j  jt            b  bt           req addr          dlv
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h0,        1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h4,        1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h40,      1, 32'h8,        0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h40,       1));
        vecs.push_back(mk(1, 0, 1, 32'h200,      1, 32'h100,     1, 32'h44,       0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,       1, 32'h44,       0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,       1, 32'h44,       0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h44,       0));
        vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,       1, 32'h200,      0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'hFFFFFFFC, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h0,        1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,       1, 32'h4,        0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,       1, 32'h4,        1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h8,        1));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,       1, 32'hC,        1));
        vecs.push_back(mk(1, 0, 1, 32'h102,      0, 32'h0,       0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,       0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h100,      1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h300,     1, 32'h104,      0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h33F,     1, 32'h104,      0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h104,      0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,       1, 32'h33C,      1));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc", pc_out, 32'h0);
        checkOutput("rst_req", 32'(imem_bus.imem_req), 32'h0);
        checkOutput("rst_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_err", 32'(fetch_err), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus($sformatf("v%0d", i), vecs[i]);

        // Fetch of 0x340 never completes: the sixteenth waiting cycle trips the timeout.
        for (int k = 1; k <= 16; k++) begin
            v = mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h340, 0);
            v.exp_err = (k == 16);
            applyStimulus($sformatf("to%0d", k), v);
        end
        for (int k = 0; k < 3; k++) begin
            v = mk(0, 1, 1, 32'h500, 1, 32'h600, 0, 32'h0, 0);
            v.exp_err = 1'b1;
            applyStimulus($sformatf("err%0d", k), v);
            checkOutput($sformatf("err%0d_pc", k), pc_out, 32'h340);
        end

        rst = 1'b0;
        #1;
        checkOutput("rst2_err", 32'(fetch_err), 32'h0);
        checkOutput("rst2_pc", pc_out, 32'h0);
        checkOutput("rst2_req", 32'(imem_bus.imem_req), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        applyStimulus("mid0", mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0));
        applyStimulus("mid1", mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0));
        rst = 1'b0;
        #1;
        checkOutput("mid_abandon_req", 32'(imem_bus.imem_req), 32'h0);

        repeat (2) @(posedge clk);
        #2;
        checkOutput("sb_drain", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side controller that owns the 32-bit program counter and sequences instruction fetches to instruction memory over a req/ready handshake. It applies pipeline stalls, branch and jump redirects, and a fetch timeout. It delivers each completed fetch to the IF stage as a one-cycle valid pulse tagged with its PC.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TIMEOUT_CYCLES, 16, consecutive FETCH cycles without imem_ready before fault; legal range 2..255.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
stall  in  1  pipeline stall; blocks issue of a new fetch.
br_taken  in  1  one-cycle pulse, taken branch resolved.
br_target  in  32  branch target, valid with br_taken.
jump  in  1  one-cycle pulse, jump resolved.
jump_target  in  32  jump target, valid with jump.
imem_req  out  1  fetch request; held until imem_ready.
imem_addr  out  32  fetch address, equals pc_out whenever imem_req=1.
imem_ready  in  1  fetch complete; instruction data is valid this cycle.
if_valid  out  1  one-cycle pulse, a fetched instruction is delivered.
if_pc  out  32  PC of the delivered instruction.
pc_out  out  32  current PC register.
fetch_err  out  1  sticky fault flag.

Behaviour:
- Reset (rst=0, async): pc_out=RESET_VECTOR, state=BOOT, imem_req=0, if_valid=0, if_pc=0, fetch_err=0, pending flag=0, timeout counter=0. Asserting reset mid-fetch abandons the request immediately.
- States: BOOT, FETCH, HOLD, ERR. All outputs are registered except imem_req and imem_addr, which are decoded from state and pc.
- BOOT: lasts one cycle after reset release. Next state is FETCH if stall=0, else HOLD.
- FETCH: imem_req=1, imem_addr=pc_out. The request is never withdrawn before imem_ready, including under stall.
  - On a completion edge (imem_ready=1), the next PC is chosen in priority order:
    - jump_target, if jump=1;
    - br_target, if br_taken=1;
    - the pending target, if the pending flag is set;
    - otherwise pc_out+4.
  - Completion outputs: if_valid=1 and if_pc=pc_out on the next cycle, unless the fetch is squashed. A fetch is squashed if jump, br_taken or pending was active at completion; a squashed fetch gives if_valid=0.
  - Completion clears the pending flag and the timeout counter. Next state is HOLD if stall=1, else FETCH; back-to-back fetches are allowed with no idle cycle.
  - A redirect pulse while imem_ready=0 latches its target into the pending register and sets the pending flag. If jump and br_taken arrive together, jump is latched. A later redirect before completion overwrites the pending target.
- HOLD: imem_req=0, if_valid=0. A redirect pulse loads pc_out directly; it does not set pending. Exit to FETCH on the first cycle with stall=0.
- Timeout: the counter increments on each FETCH cycle with imem_ready=0. When it reaches TIMEOUT_CYCLES-1 with imem_ready still 0, the next state is ERR.
- ERR: imem_req=0, fetch_err=1, pc_out frozen, all inputs ignored. The block leaves ERR only through reset.
- Arithmetic: pc_out+4 is modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000. Redirect targets have bits[1:0] forced to 0, unless the optional feature below is enabled.
- if_valid is never high two cycles in a row unless there are two distinct completions.

Optional Feature:
Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, sticky, reset 0) and output fault_addr (32 bits, reset 0).
  - A redirect target with bits[1:0]!=0 sets misalign=1 and fault_addr=target, and moves the state to ERR with fetch_err=1.
  - If this happens during FETCH, the block first waits for imem_ready (the handshake is honoured) and squashes that fetch.
- Undefined: the ports are absent and target bits[1:0] are silently forced to 0.

Test Plan:
- Reset release, stall=0, imem_ready tied 1 -> imem_addr sequence 0x0,0x4,0x8,...; if_valid pulses each cycle with if_pc=0x0,0x4,...; pc wraps 0xFFFFFFFC->0x0 when preloaded via jump.
- Redirect priority: br_taken=1 (br_target=0x100) in the same cycle as jump=1 (jump_target=0x200), during a stalled FETCH with imem_ready=0 for 3 cycles -> no if_valid for that fetch; next imem_addr=0x200.
- Redirect on the completion edge: br_target=0x40 with imem_ready=1 at pc=0x8 -> if_valid stays 0; next imem_addr=0x40.
- Stall: stall=1 held 5 cycles while imem_ready arrives on cycle 2 -> req held until ready; one if_valid; then imem_req=0 for the remaining stall; fetch of pc+4 resumes the cycle after stall drops.
- Timeout: imem_ready=0 for 16 cycles -> fetch_err=1 and imem_req=0 on cycle 17, staying so through jump pulses until rst=0.
- With PC_MISALIGN_TRAP_EN: jump_target=0x102 in HOLD -> misalign=1, fault_addr=0x102, fetch_err=1 next cycle; without the macro -> next imem_addr=0x100.
